// File: rtl/mem_request_driver.sv
// -----------------------------------------------------------------------------
// mem_request_driver
//
// Loadable request sequencer for memory-hierarchy test setups. A table of
// DEPTH read/write requests is written while idle. A start pulse then issues
// entries 0..num_req-1 one at a time over a valid/ack handshake. Read data,
// page faults and timeouts are recorded for the bench or self-test to inspect.
//
// Handshake: req_valid rises with req_* already valid and both stay stable
// until the driver sees req_ack=1 in a WAIT cycle (rsp_fault qualifies that
// ack) or until the wait counter expires. req_valid then drops for at least
// one cycle before the next request is presented. An ack seen while idle or
// in ISSUE is ignored.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   load_*           table write port, honoured only in IDLE
//   start, num_req   begin a sequence of num_req (1..DEPTH) requests
//   req_*            request presented to the memory system
//   req_ack, rsp_*   completion, read data and page-fault flag
//   busy, done, err  sequence status (done is a single-cycle pulse)
//   cur_idx          index of the current/next request
//   last_rdata       data of the most recent successful read
//   fault_cnt        page faults seen in the current sequence
//   timeout_cnt      timeouts seen in the current sequence
//   o_dbg_state      FSM state, for checkers
// -----------------------------------------------------------------------------
module mem_request_driver #(
  parameter int ADDR_W        = 14,
  parameter int DATA_W        = 32,
  parameter int DEPTH         = 16,
  parameter int TIMEOUT       = 64,
  parameter int STOP_ON_FAULT = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_en,
  input  logic [$clog2(DEPTH)-1:0]   load_idx,
  input  logic                       load_rw,
  input  logic [2:0]                 load_funct,
  input  logic [ADDR_W-1:0]          load_addr,
  input  logic [DATA_W-1:0]          load_wdata,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     num_req,
  output logic                       req_valid,
  output logic                       req_rw,
  output logic [2:0]                 req_funct,
  output logic [ADDR_W-1:0]          req_addr,
  output logic [DATA_W-1:0]          req_wdata,
  input  logic                       req_ack,
  input  logic [DATA_W-1:0]          rsp_rdata,
  input  logic                       rsp_fault,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(DEPTH):0]     cur_idx,
  output logic [DATA_W-1:0]          last_rdata,
  output logic [$clog2(DEPTH):0]     fault_cnt,
  output logic [$clog2(DEPTH):0]     timeout_cnt,
  output logic [1:0]                 o_dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int WC_W  = $clog2(TIMEOUT);
  localparam int ENT_W = 4 + ADDR_W + DATA_W;
  localparam bit STOP  = (STOP_ON_FAULT != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t             r_state;
  logic [ENT_W-1:0]   r_tab [DEPTH];
  logic [ENT_W-1:0]   r_req_entry;
  logic               r_req_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [CNT_W-1:0]   r_cur_idx;
  logic [CNT_W-1:0]   r_num_req;
  logic [CNT_W-1:0]   r_fault_cnt;
  logic [CNT_W-1:0]   r_timeout_cnt;
  logic [DATA_W-1:0]  r_last_rdata;
  logic [WC_W-1:0]    r_wait_cnt;

  logic [ENT_W-1:0]   w_load_entry;
  logic [ENT_W-1:0]   w_first_entry;
  logic [ENT_W-1:0]   w_cur_entry;
  logic               w_load_ok;
  logic               w_num_ok;
  logic               w_in_wait;
  logic               w_ack_ok;
  logic               w_ack_fault;
  logic               w_timeout;
  logic               w_stop;
  logic               w_advance;
  logic               w_last;

  assign w_load_entry = {load_rw, load_funct, load_addr, load_wdata};
  assign w_load_ok    = load_en && (r_state == S_IDLE);

  // Entry 0 is captured on the start edge itself, so a load of entry 0 in the
  // same cycle is forwarded rather than read from the not-yet-written table.
  assign w_first_entry = (w_load_ok && (load_idx == '0)) ? w_load_entry : r_tab[0];
  assign w_cur_entry   = r_tab[r_cur_idx[IDX_W-1:0]];

  assign w_num_ok    = (num_req != '0) && (num_req <= CNT_W'(DEPTH));
  assign w_in_wait   = (r_state == S_WAIT);
  assign w_ack_ok    = w_in_wait && req_ack && !rsp_fault;
  assign w_ack_fault = w_in_wait && req_ack && rsp_fault;
  assign w_timeout   = w_in_wait && !req_ack && (r_wait_cnt == WC_W'(TIMEOUT - 1));
  assign w_stop      = w_ack_fault && STOP;
  assign w_advance   = w_ack_ok || (w_ack_fault && !STOP) || w_timeout;
  assign w_last      = ((r_cur_idx + CNT_W'(1)) == r_num_req);

  // Request table: no reset, an entry is undefined until loaded.
  always_ff @(posedge clk) begin
    if (w_load_ok) begin
      r_tab[load_idx] <= w_load_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_req_entry   <= '0;
      r_req_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_cur_idx     <= '0;
      r_num_req     <= '0;
      r_fault_cnt   <= '0;
      r_timeout_cnt <= '0;
      r_last_rdata  <= '0;
      r_wait_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cur_idx     <= '0;
            r_fault_cnt   <= '0;
            r_timeout_cnt <= '0;
            r_num_req     <= num_req;
            if (w_num_ok) begin
              r_err       <= 1'b0;
              r_busy      <= 1'b1;
              r_req_valid <= 1'b1;
              r_req_entry <= w_first_entry;
              r_state     <= S_ISSUE;
            end else begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end

        S_ISSUE: begin
          r_req_valid <= 1'b1;
          r_req_entry <= w_cur_entry;
          r_wait_cnt  <= '0;
          r_state     <= S_WAIT;
        end

        S_WAIT: begin
          if (w_ack_ok && !r_req_entry[ENT_W-1]) begin
            r_last_rdata <= rsp_rdata;
          end
          if (w_ack_fault && (r_fault_cnt != '1)) begin
            r_fault_cnt <= r_fault_cnt + CNT_W'(1);
          end
          if (w_timeout && (r_timeout_cnt != '1)) begin
            r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
          end
          if (w_timeout || w_stop) begin
            r_err <= 1'b1;
          end

          if (w_advance) begin
            // Dropping valid here produces the bubble before the next request.
            r_req_valid <= 1'b0;
            r_cur_idx   <= r_cur_idx + CNT_W'(1);
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_state <= S_ISSUE;
            end
          end else if (w_stop) begin
            // Halt on the faulting entry; cur_idx keeps pointing at it.
            r_req_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_FIN;
          end else begin
            r_wait_cnt <= r_wait_cnt + WC_W'(1);
          end
        end

        S_FIN: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_valid   = r_req_valid;
  assign {req_rw, req_funct, req_addr, req_wdata} = r_req_entry;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign cur_idx     = r_cur_idx;
  assign last_rdata  = r_last_rdata;
  assign fault_cnt   = r_fault_cnt;
  assign timeout_cnt = r_timeout_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_request_driver.sv
// -----------------------------------------------------------------------------
// Bench for mem_request_driver. Two instances share all inputs:
//   dut0: STOP_ON_FAULT=0, TIMEOUT=8 (main instance, fully scoreboarded)
//   dut1: STOP_ON_FAULT=1, TIMEOUT=8 (checked in the page-fault scenario)
// A negedge responder acks dut0's requests after ack_delay valid cycles,
// optionally withholding the ack or flagging a fault for one index. The
// scoreboard holds the table entries expected on each new request.
// -----------------------------------------------------------------------------
module tb_mem_request_driver;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ENT_W  = 4 + ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              load_en = 1'b0;
  logic [3:0]        load_idx = '0;
  logic              load_rw = 1'b0;
  logic [2:0]        load_funct = '0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [DATA_W-1:0] load_wdata = '0;
  logic              start = 1'b0;
  logic [4:0]        num_req = '0;
  logic              req_ack = 1'b0;
  logic [DATA_W-1:0] rsp_rdata = '0;
  logic              rsp_fault = 1'b0;

  logic              req_valid, req_rw, busy, done, err;
  logic [2:0]        req_funct;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata, last_rdata;
  logic [4:0]        cur_idx, fault_cnt, timeout_cnt;
  logic [1:0]        dbg_state;

  logic              req1_valid, req1_rw, busy1, done1, err1;
  logic [2:0]        req1_funct;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata, last1_rdata;
  logic [4:0]        cur1_idx, fault1_cnt, timeout1_cnt;
  logic [1:0]        dbg1_state;

  mem_request_driver #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                       .TIMEOUT(8), .STOP_ON_FAULT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_idx(load_idx), .load_rw(load_rw),
    .load_funct(load_funct), .load_addr(load_addr), .load_wdata(load_wdata),
    .start(start), .num_req(num_req),
    .req_valid(req_valid), .req_rw(req_rw), .req_funct(req_funct),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .busy(busy), .done(done), .err(err), .cur_idx(cur_idx),
    .last_rdata(last_rdata), .fault_cnt(fault_cnt), .timeout_cnt(timeout_cnt),
    .o_dbg_state(dbg_state)
  );

  mem_request_driver #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                       .TIMEOUT(8), .STOP_ON_FAULT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_idx(load_idx), .load_rw(load_rw),
    .load_funct(load_funct), .load_addr(load_addr), .load_wdata(load_wdata),
    .start(start), .num_req(num_req),
    .req_valid(req1_valid), .req_rw(req1_rw), .req_funct(req1_funct),
    .req_addr(req1_addr), .req_wdata(req1_wdata),
    .req_ack(req_ack), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .busy(busy1), .done(done1), .err(err1), .cur_idx(cur1_idx),
    .last_rdata(last1_rdata), .fault_cnt(fault1_cnt), .timeout_cnt(timeout1_cnt),
    .o_dbg_state(dbg1_state)
  );

  // ---------------- scoreboard state ----------------
  logic [ENT_W-1:0]  exp_q[$];
  logic [ENT_W-1:0]  bt [DEPTH];       // bench copy of the table
  logic [DATA_W-1:0] rd_data [DEPTH];  // read data returned per index
  int n_tests = 0;
  int n_fail  = 0;
  int n_issued = 0;
  int n_issued1 = 0;
  int done_cnt = 0;
  int run_len [DEPTH];
  int vcnt = 0;
  int ack_delay = 2;
  logic noack_en = 1'b0;
  logic [4:0] noack_idx = '0;
  logic fault_en = 1'b0;
  logic [4:0] fault_idx = '0;
  logic prev_valid = 1'b0;
  logic prev1_valid = 1'b0;
  logic [DATA_W-1:0] exp_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ENT_W-1:0] mk(input logic rw, input logic [2:0] f,
                                          input logic [ADDR_W-1:0] a,
                                          input logic [DATA_W-1:0] d);
    return {rw, f, a, d};
  endfunction

  // ---------------- monitor + responder ----------------
  always @(negedge clk) begin
    if (req_valid) begin
      vcnt++;
      run_len[cur_idx[3:0]]++;
      if (!prev_valid) begin
        n_issued++;
        if (exp_q.size() == 0) check("req_unexpected", 64'd1, 64'd0);
        else check("req_fields", {req_rw, req_funct, req_addr, req_wdata}, exp_q.pop_front());
      end
    end else begin
      vcnt = 0;
    end
    prev_valid = req_valid;
    if (req1_valid && !prev1_valid) n_issued1++;
    prev1_valid = req1_valid;
    if (done) done_cnt++;
    req_ack   = req_valid && (vcnt >= ack_delay) && !(noack_en && cur_idx == noack_idx);
    rsp_fault = req_ack && fault_en && (cur_idx == fault_idx);
    rsp_rdata = rd_data[cur_idx[3:0]];
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    n_issued = 0; n_issued1 = 0; done_cnt = 0;
    for (int i = 0; i < DEPTH; i++) run_len[i] = 0;
  endtask

  task automatic push_seq(input int n);
    if (n >= 1 && n <= DEPTH)
      for (int i = 0; i < n; i++) exp_q.push_back(bt[i]);
  endtask

  task automatic do_load(input int idx, input logic [ENT_W-1:0] e);
    @(negedge clk);
    load_en = 1'b1; load_idx = 4'(idx);
    {load_rw, load_funct, load_addr, load_wdata} = e;
    bt[idx] = e;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    clear_stats();
    push_seq(n);
    start = 1'b1; num_req = 5'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Load one entry and start in the same cycle.
  task automatic load_start(input int idx, input logic [ENT_W-1:0] e, input int n);
    @(negedge clk);
    clear_stats();
    load_en = 1'b1; load_idx = 4'(idx);
    {load_rw, load_funct, load_addr, load_wdata} = e;
    bt[idx] = e;
    push_seq(n);
    start = 1'b1; num_req = 5'(n);
    @(negedge clk);
    load_en = 1'b0; start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!done) check({tag, "_done_timeout"}, 64'd0, 64'd1);
    repeat (2) @(negedge clk);
  endtask

  logic [ENT_W-1:0] tmp_e;

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      rd_data[i] = $urandom;
      run_len[i] = 0;
      bt[i] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_valid", req_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cur_idx", cur_idx, 0);
    check("rst_last_rdata", last_rdata, 0);
    check("rst_counts", {fault_cnt, timeout_cnt}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic 3-entry run; entry 0 loaded in the start cycle; load/start while busy ignored
    ack_delay = 2;
    rd_data[2] = 32'hDAC;
    do_load(1, mk(1'b1, 3'b010, 14'h009C, 32'h0000_0DAC));
    do_load(2, mk(1'b0, 3'b010, 14'h0098, 32'h0));
    load_start(0, mk(1'b1, 3'b010, 14'h0898, 32'h0000_0148), 3);
    load_en = 1'b1; load_idx = 4'd2;
    {load_rw, load_funct, load_addr, load_wdata} = mk(1'b1, 3'b000, 14'h3FFF, 32'hDEAD_BEEF);
    start = 1'b1; num_req = 5'd1;
    @(negedge clk);
    load_en = 1'b0; start = 1'b0;
    wait_done("basic");
    check("basic_last_rdata", last_rdata, 32'hDAC);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_err", err, 0);
    check("basic_fault_cnt", fault_cnt, 0);
    check("basic_cur_idx", cur_idx, 3);
    check("basic_issued", n_issued, 3);
    check("basic_busy", busy, 0);

    // Page fault on entry 2 with minimum-latency acks
    ack_delay = 1;
    fault_en = 1'b1; fault_idx = 5'd2;
    do_load(0, mk(1'b0, 3'b010, 14'($urandom), 32'h0));
    do_load(1, mk(1'b1, 3'b000, 14'($urandom), $urandom));
    do_load(2, mk(1'b0, 3'b010, 14'($urandom), 32'h0));
    do_load(3, mk(1'b1, 3'b010, 14'($urandom), $urandom));
    do_start(4);
    wait_done("fault");
    fault_en = 1'b0;
    check("fault_cnt", fault_cnt, 1);
    check("fault_issued", n_issued, 4);
    check("fault_err", err, 0);
    check("fault_done_cnt", done_cnt, 1);
    check("fault_cur_idx", cur_idx, 4);
    check("fault_last_rdata", last_rdata, rd_data[0]);
    check("stop_cur_idx", cur1_idx, 2);
    check("stop_err", err1, 1);
    check("stop_issued", n_issued1, 3);
    check("stop_fault_cnt", fault1_cnt, 1);
    check("stop_busy", busy1, 0);

    // Timeout on entry 1
    ack_delay = 2;
    noack_en = 1'b1; noack_idx = 5'd1;
    for (int i = 0; i < 3; i++) do_load(i, mk(1'($urandom), 3'b010, 14'($urandom), $urandom));
    do_start(3);
    wait_done("tmo");
    noack_en = 1'b0;
    check("tmo_valid_cycles", run_len[1], 8);
    check("tmo_cnt", timeout_cnt, 1);
    check("tmo_err", err, 1);
    check("tmo_cur_idx", cur_idx, 3);
    check("tmo_issued", n_issued, 3);
    check("tmo_fault_cnt", fault_cnt, 0);

    // Illegal num_req values
    do_start(0);
    check("n0_done", done, 1);
    check("n0_valid", req_valid, 0);
    check("n0_err", err, 1);
    @(negedge clk);
    check("n0_done_low", done, 0);
    check("n0_issued", n_issued, 0);
    do_start(17);
    check("n17_done", done, 1);
    check("n17_err", err, 1);
    repeat (2) @(negedge clk);
    check("n17_issued", n_issued, 0);

    // Full table, random contents and ack latency
    ack_delay = $urandom_range(1, 3);
    for (int i = 0; i < DEPTH; i++) begin
      tmp_e = mk((i == 0) ? 1'b0 : 1'($urandom), ($urandom_range(0, 1) != 0) ? 3'b010 : 3'b000,
                 14'($urandom), $urandom);
      do_load(i, tmp_e);
      rd_data[i] = $urandom;
      if (!tmp_e[ENT_W-1]) exp_last = rd_data[i];
    end
    do_start(DEPTH);
    wait_done("full");
    check("full_cur_idx", cur_idx, 16);
    check("full_issued", n_issued, 16);
    check("full_err", err, 0);
    check("full_done_cnt", done_cnt, 1);
    check("full_last_rdata", last_rdata, exp_last);
    check("full_queue_empty", exp_q.size(), 0);

    // Asynchronous reset during WAIT of entry 1, then re-run
    ack_delay = 2;
    noack_en = 1'b1; noack_idx = 5'd1;
    for (int i = 0; i < 3; i++) do_load(i, mk(1'($urandom), 3'b010, 14'($urandom), $urandom));
    do_start(3);
    begin
      int k;
      k = 0;
      while (!(req_valid && cur_idx == 5'd1) && k < 200) begin
        @(negedge clk);
        k++;
      end
      check("arst_reached_wait", {req_valid, cur_idx}, {1'b1, 5'd1});
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", req_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_cur_idx", cur_idx, 0);
    check("arst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    noack_en = 1'b0;
    exp_q.delete();
    @(negedge clk);
    do_start(3);
    wait_done("rerun");
    check("rerun_issued", n_issued, 3);
    check("rerun_cur_idx", cur_idx, 3);
    check("rerun_err", err, 0);
    check("rerun_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_request_driver.md
Name: mem_request_driver

Overview:
- Parametrised request sequencer that replaces the fixed-table processor stub in the memory-hierarchy benches (TLB, cache, page table, main memory).
- Holds a loadable table of read/write requests and issues them one at a time over a valid/ack handshake.
- Captures read data and counts completions, page faults and timeouts, so benches and FPGA self-tests can run arbitrary request sequences without editing RTL.

Parameters:
ADDR_W, 14, virtual address width
DATA_W, 32, write/read data width
DEPTH, 16, request table entries (power of 2, >=2)
TIMEOUT, 64, max cycles to wait for ack before aborting a request (>=2)
STOP_ON_FAULT, 0, 1 = halt sequence on page fault; 0 = count fault and continue

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
load_en  in  1  write one table entry this cycle (accepted only in IDLE)
load_idx  in  log2(DEPTH)  entry index
load_rw  in  1  1 = write, 0 = read
load_funct  in  3  access size: 000 byte, 010 word
load_addr  in  ADDR_W  virtual address
load_wdata  in  DATA_W  write data
start  in  1  pulse: begin sequence (accepted only in IDLE)
num_req  in  log2(DEPTH)+1  number of entries to issue, 1..DEPTH; sampled on start
req_valid  out  1  request presented
req_rw  out  1  request direction
req_funct  out  3  request size
req_addr  out  ADDR_W  request address
req_wdata  out  DATA_W  request write data
req_ack  in  1  request completed (cache done/hit)
rsp_rdata  in  DATA_W  read data, valid with req_ack
rsp_fault  in  1  page fault, qualifies req_ack
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at sequence end
err  out  1  sticky: timeout or stop-on-fault occurred; cleared on start
cur_idx  out  log2(DEPTH)+1  index of the current/next request
last_rdata  out  DATA_W  data of the most recent successful read
fault_cnt  out  log2(DEPTH)+1  faults in the current sequence
timeout_cnt  out  log2(DEPTH)+1  timeouts in the current sequence

Behaviour:
- Reset: all outputs 0 and state IDLE. Table contents are not reset; an entry is undefined until loaded.
- States:
  - IDLE -> ISSUE on start with num_req in 1..DEPTH. start with num_req=0 or >DEPTH: go straight to FIN, set err.
  - ISSUE: drive entry cur_idx with req_valid=1 and clear the wait counter -> WAIT next cycle. req_* already valid in ISSUE.
  - WAIT: req_valid held 1 and req_* held stable.
    - req_ack=1, rsp_fault=0: if read, last_rdata<=rsp_rdata. Advance.
    - req_ack=1, rsp_fault=1: fault_cnt++. If STOP_ON_FAULT=1, set err -> FIN; otherwise advance.
    - No ack with wait counter = TIMEOUT-1: timeout_cnt++, set err, advance (request skipped).
  - Advance: cur_idx++. If cur_idx+1 == num_req -> FIN, else -> ISSUE. This gives a one-cycle req_valid=0 bubble between requests.
  - FIN: done=1 for exactly one cycle, busy=0 -> IDLE.
- busy=1 in ISSUE and WAIT.
- On start, cur_idx, fault_cnt, timeout_cnt and err clear. last_rdata holds its value.
- Request latency: req_valid rises 1 cycle after start. Minimum per-request time is 2 cycles (ack in the first WAIT cycle).
- req_ack arriving in ISSUE or IDLE is ignored.
- load_en outside IDLE is ignored, so the table is stable while busy. load_en and start in the same IDLE cycle: load is written first, and the sequence sees the new entry.
- start while busy is ignored.
- Counters saturate at their maximum value; they never wrap.
- rst_n low mid-sequence: immediately IDLE, req_valid=0 asynchronously, counters 0.

Test Plan:
- Load 3 entries (sw 0x0148 @0x0898, sw 0xDAC @0x009C, lw @0x0098); start num_req=3; ack each 2 cycles after valid, returning 0xDAC on the read -> last_rdata=0xDAC, done pulse once, err=0, fault_cnt=0.
- STOP_ON_FAULT=0, 4 entries, assert rsp_fault with ack on entry 2 -> fault_cnt=1, all 4 requests issued, err=0, done pulses.
- STOP_ON_FAULT=1, same stimulus -> sequence ends after entry 2, cur_idx=2, err=1, entry 3 never issued.
- Never ack entry 1 (TIMEOUT=8) -> req_valid held exactly 8 WAIT cycles, timeout_cnt=1, err=1, sequence continues to entry 2.
- start with num_req=0 -> no req_valid, done next cycle, err=1. Then start with num_req=DEPTH -> all 16 issued and cur_idx ends at 16.
- Deassert rst_n during WAIT of entry 1 -> req_valid=0 without a clock edge, busy=0. After release, a restart with start re-runs from entry 0.
